// File: rtl/key_tracker_pkg.sv
// Shared game constants: lane count, PS/2 prefix bytes and decoder states.
package key_tracker_pkg;

  localparam int LANES = 8;

  localparam logic [7:0] BREAK_PFX = 8'hF0;
  localparam logic [7:0] EXT_PFX   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_t;

endpackage

// File: rtl/key_tracker_scancode_lane_map.sv
// Combinational scancode-to-lane lookup: one-hot lane vector plus a hit flag.
import key_tracker_pkg::*;

module scancode_lane_map #(
  parameter logic [7:0] KEY7 = 8'h1C,
  parameter logic [7:0] KEY6 = 8'h1B,
  parameter logic [7:0] KEY5 = 8'h23,
  parameter logic [7:0] KEY4 = 8'h2B,
  parameter logic [7:0] KEY3 = 8'h3B,
  parameter logic [7:0] KEY2 = 8'h42,
  parameter logic [7:0] KEY1 = 8'h4B,
  parameter logic [7:0] KEY0 = 8'h4C
) (
  input  logic [7:0]       code_byte,
  output logic [LANES-1:0] lane,
  output logic             hit
);

  assign lane[7] = (code_byte == KEY7);
  assign lane[6] = (code_byte == KEY6);
  assign lane[5] = (code_byte == KEY5);
  assign lane[4] = (code_byte == KEY4);
  assign lane[3] = (code_byte == KEY3);
  assign lane[2] = (code_byte == KEY2);
  assign lane[1] = (code_byte == KEY1);
  assign lane[0] = (code_byte == KEY0);
  assign hit     = |lane;

endmodule

// File: rtl/key_tracker.sv
// PS/2 Set-2 lane decoder: live make/break tracking, frame-aligned lane
// snapshot, per-frame strike pulses and prefix timeout recovery.
import key_tracker_pkg::*;

module key_tracker #(
  parameter logic [7:0] KEY7 = 8'h1C,
  parameter logic [7:0] KEY6 = 8'h1B,
  parameter logic [7:0] KEY5 = 8'h23,
  parameter logic [7:0] KEY4 = 8'h2B,
  parameter logic [7:0] KEY3 = 8'h3B,
  parameter logic [7:0] KEY2 = 8'h42,
  parameter logic [7:0] KEY1 = 8'h4B,
  parameter logic [7:0] KEY0 = 8'h4C,
  parameter int         PREFIX_TIMEOUT = 50000,
  parameter int         TO_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             code_valid,
  input  logic [7:0]       code_byte,
  input  logic             frame_sync,
  output logic [LANES-1:0] keyTrack,
  output logic [LANES-1:0] strike,
  output logic [LANES-1:0] live_keys,
  output logic             err_timeout
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);

  dec_state_t       state_r;
  dec_state_t       state_nxt_s;
  logic [TO_W-1:0]  to_cnt_r;
  logic [LANES-1:0] pending_r;
  logic [LANES-1:0] map_lane_s;
  logic             map_hit_s;
  logic [LANES-1:0] set_ev_s;
  logic [LANES-1:0] clr_ev_s;
  logic [LANES-1:0] live_nxt_s;
  logic             to_fire_s;

  scancode_lane_map #(
    .KEY7(KEY7), .KEY6(KEY6), .KEY5(KEY5), .KEY4(KEY4),
    .KEY3(KEY3), .KEY2(KEY2), .KEY1(KEY1), .KEY0(KEY0)
  ) u_map (
    .code_byte (code_byte),
    .lane      (map_lane_s),
    .hit       (map_hit_s)
  );

  // A prefix state gives up when its wait budget is spent and no byte arrives.
  assign to_fire_s = (state_r != IDLE) && !code_valid && (to_cnt_r == TO_LAST);

  // Only genuinely new presses set a lane; repeats of held keys are filtered out.
  assign live_nxt_s = (live_keys | set_ev_s) & ~clr_ev_s;

  // Decoder next-state and per-byte lane set/clear events.
  always_comb begin
    state_nxt_s = state_r;
    set_ev_s    = 8'h00;
    clr_ev_s    = 8'h00;
    case (state_r)
      IDLE: begin
        if (code_valid) begin
          if (code_byte == BREAK_PFX) begin
            state_nxt_s = BRK;
          end else if (code_byte == EXT_PFX) begin
            state_nxt_s = EXT;
          end else if (map_hit_s) begin
            set_ev_s = map_lane_s & ~live_keys;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BRK: begin
        if (code_valid) begin
          state_nxt_s = IDLE;
          clr_ev_s    = map_hit_s ? map_lane_s : 8'h00;
        end else if (to_fire_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BRK;
        end
      end
      EXT: begin
        if (code_valid) begin
          state_nxt_s = (code_byte == BREAK_PFX) ? EXT_BRK : IDLE;
        end else if (to_fire_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = EXT;
        end
      end
      EXT_BRK: begin
        if (code_valid || to_fire_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = EXT_BRK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Decoder state register and prefix timeout counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= IDLE;
      to_cnt_r    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      err_timeout <= to_fire_s;
      if ((state_r == IDLE) || code_valid || to_fire_s) begin
        to_cnt_r <= '0;
      end else begin
        to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Live lane state, pending strikes and the frame-boundary snapshot.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      live_keys <= 8'h00;
      pending_r <= 8'h00;
      keyTrack  <= 8'h00;
      strike    <= 8'h00;
    end else begin
      live_keys <= live_nxt_s;
      if (frame_sync) begin
        keyTrack  <= live_nxt_s;
        strike    <= pending_r | set_ev_s;
        pending_r <= 8'h00;
      end else begin
        strike    <= 8'h00;
        pending_r <= pending_r | set_ev_s;
      end
    end
  end

endmodule

// File: tb/tb_key_tracker.sv
// Directed self-checking bench for key_tracker.
module tb_key_tracker;

  localparam int P = 64;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code_byte = 8'h00;
  logic       frame_sync = 1'b0;
  logic [7:0] keyTrack;
  logic [7:0] strike;
  logic [7:0] live_keys;
  logic       err_timeout;

  int checks = 0;
  int errors = 0;

  key_tracker #(.PREFIX_TIMEOUT(P), .TO_W(16)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .code_valid  (code_valid),
    .code_byte   (code_byte),
    .frame_sync  (frame_sync),
    .keyTrack    (keyTrack),
    .strike      (strike),
    .live_keys   (live_keys),
    .err_timeout (err_timeout)
  );

  always #5 Clk = ~Clk;

  // All stimulus starts and ends on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    code_valid = 1'b1;
    code_byte  = b;
    @(negedge Clk);
    code_valid = 1'b0;
    code_byte  = 8'h00;
  endtask

  task automatic frame();
    frame_sync = 1'b1;
    @(negedge Clk);
    frame_sync = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    do_reset();
    send_byte(8'h1C);
    send_byte(8'hF0);
    checks++;
    if (live_keys !== 8'h80) begin errors++; $display("FAIL pre_reset_live got %h want 80", live_keys); end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({keyTrack, strike, live_keys, err_timeout} !== 25'h0) begin
      errors++; $display("FAIL async_reset got kt=%h st=%h lv=%h er=%b want all 0", keyTrack, strike, live_keys, err_timeout);
    end
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    send_byte(8'h23);
    frame();
    checks++;
    if (keyTrack !== 8'h20) begin errors++; $display("FAIL reset_kt got %h want 20", keyTrack); end
    checks++;
    if (strike !== 8'h20) begin errors++; $display("FAIL reset_strike got %h want 20", strike); end
    @(negedge Clk);
    checks++;
    if (strike !== 8'h00) begin errors++; $display("FAIL reset_strike_clr got %h want 00", strike); end
  endtask

  task automatic test_two_lanes();
    do_reset();
    send_byte(8'h1C);
    send_byte(8'h4C);
    frame();
    checks++;
    if (keyTrack !== 8'h81) begin errors++; $display("FAIL two_kt got %h want 81", keyTrack); end
    checks++;
    if (strike !== 8'h81) begin errors++; $display("FAIL two_strike got %h want 81", strike); end
    send_byte(8'hF0);
    send_byte(8'h1C);
    frame();
    checks++;
    if (keyTrack !== 8'h01) begin errors++; $display("FAIL release_kt got %h want 01", keyTrack); end
    checks++;
    if (strike !== 8'h00) begin errors++; $display("FAIL release_strike got %h want 00", strike); end
  endtask

  task automatic test_tap_in_frame();
    do_reset();
    send_byte(8'h3B);
    send_byte(8'hF0);
    send_byte(8'h3B);
    frame();
    checks++;
    if (keyTrack !== 8'h00) begin errors++; $display("FAIL tap_kt got %h want 00", keyTrack); end
    checks++;
    if (strike !== 8'h08) begin errors++; $display("FAIL tap_strike got %h want 08", strike); end
    checks++;
    if (live_keys !== 8'h00) begin errors++; $display("FAIL tap_live got %h want 00", live_keys); end
  endtask

  task automatic test_typematic();
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h42);
    frame();
    checks++;
    if (strike !== 8'h04 || keyTrack !== 8'h04) begin
      errors++; $display("FAIL typ_f1 got st=%h kt=%h want 04/04", strike, keyTrack);
    end
    for (int i = 0; i < 2; i++) send_byte(8'h42);
    frame();
    checks++;
    if (strike !== 8'h00 || keyTrack !== 8'h04) begin
      errors++; $display("FAIL typ_f2 got st=%h kt=%h want 00/04", strike, keyTrack);
    end
  endtask

  task automatic test_extended();
    int pulses;
    int first;
    do_reset();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    checks++;
    if (live_keys !== 8'h00) begin errors++; $display("FAIL ext_brk_live got %h want 00", live_keys); end
    send_byte(8'hE0);
    send_byte(8'h1C);
    checks++;
    if (live_keys !== 8'h00) begin errors++; $display("FAIL ext_make_live got %h want 00", live_keys); end
    send_byte(8'h1C);
    checks++;
    if (live_keys !== 8'h80) begin errors++; $display("FAIL plain_make_live got %h want 80", live_keys); end
    send_byte(8'hE0);
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= P + 20; i++) begin
      @(negedge Clk);
      if (err_timeout === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL timeout_pulses got %0d want 1", pulses); end
    checks++;
    if (first !== P) begin errors++; $display("FAIL timeout_cycle got %0d want %0d", first, P); end
    checks++;
    if (live_keys !== 8'h80) begin errors++; $display("FAIL timeout_live got %h want 80", live_keys); end
    send_byte(8'h1B);
    checks++;
    if (live_keys !== 8'hC0) begin errors++; $display("FAIL post_timeout_live got %h want c0", live_keys); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    code_valid = 1'b1;
    code_byte  = 8'h2B;
    frame_sync = 1'b1;
    @(negedge Clk);
    code_valid = 1'b0;
    frame_sync = 1'b0;
    checks++;
    if (keyTrack !== 8'h10) begin errors++; $display("FAIL same_kt got %h want 10", keyTrack); end
    checks++;
    if (strike !== 8'h10) begin errors++; $display("FAIL same_strike got %h want 10", strike); end
    checks++;
    if (live_keys !== 8'h10) begin errors++; $display("FAIL same_live got %h want 10", live_keys); end
    @(negedge Clk);
    frame();
    checks++;
    if (strike !== 8'h00 || keyTrack !== 8'h10) begin
      errors++; $display("FAIL same_next_frame got st=%h kt=%h want 00/10", strike, keyTrack);
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_two_lanes();
    test_tap_in_frame();
    test_typematic();
    test_extended();
    test_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_tracker.md
Name: key_tracker

Overview:
- Decodes the PS/2 Set-2 scancode byte stream into the 8-lane `keyTrack` vector used by the lane-rectangle renderer and the note-hit logic.
- Tracks live make/break state per lane, and publishes `keyTrack` only at frame boundaries so a lane's highlight never changes mid-frame.
- Emits a one-cycle strike pulse per lane for new presses, for the hit judge.
- Sits between the PS/2 byte receiver and the video/game logic.

Parameters:
- KEY7, default 8'h1C, scancode for lane 7 (A, leftmost)
- KEY6, default 8'h1B, scancode for lane 6 (S)
- KEY5, default 8'h23, scancode for lane 5 (D)
- KEY4, default 8'h2B, scancode for lane 4 (F)
- KEY3, default 8'h3B, scancode for lane 3 (J)
- KEY2, default 8'h42, scancode for lane 2 (K)
- KEY1, default 8'h4B, scancode for lane 1 (L)
- KEY0, default 8'h4C, scancode for lane 0 (;, rightmost)
- PREFIX_TIMEOUT, default 50000, cycles a prefix state may wait for its next byte before abandoning
- TO_W, default 16, width of the timeout counter

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- code_valid  in  1  one-cycle strobe: code_byte is valid
- code_byte  in  8  received scancode byte
- frame_sync  in  1  one-cycle pulse at start of vertical blank
- keyTrack  out  8  per-lane held state, frame-aligned; bit 7 = leftmost lane
- strike  out  8  one-cycle pulse, per lane, of presses newly made during the last frame
- live_keys  out  8  per-lane held state, updated immediately (not frame-aligned)
- err_timeout  out  1  one-cycle pulse when a prefix timeout fires

Behaviour:
- Reset (async, active-high) clears everything:
  - keyTrack, strike, live_keys, err_timeout = 0
  - pending strike register = 0
  - FSM = IDLE
  - timeout counter = 0
- Decoder FSM states: IDLE, BRK, EXT, EXT_BRK. Transitions occur only on code_valid, except for timeout.
  - IDLE: F0 -> BRK; E0 -> EXT; lane scancode -> set live bit, stay IDLE; any other byte ignored, stay IDLE.
  - BRK: lane scancode -> clear live bit; any byte -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte -> IDLE. Extended keys never map to lanes.
  - EXT_BRK: any byte -> IDLE, no lane effect.
- Timeout:
  - The counter runs only in BRK, EXT and EXT_BRK, and clears on any code_valid or on a return to IDLE.
  - When it reaches PREFIX_TIMEOUT-1 with no byte arriving: FSM -> IDLE, err_timeout pulses for 1 cycle, live state unchanged.
- Typematic repeat: a make code for a lane whose live bit is already 1 causes no state change and no strike.
- A break code for a lane that is already released is a no-op.
- Pending strike: a set event on a lane whose live bit was 0 ORs that lane into the pending register. This means a press and release within a single frame still yields a strike.
- On frame_sync, with 1-cycle latency:
  - keyTrack <= next-cycle value of live_keys
  - strike <= pending | same-cycle set events
  - pending <= 0
  - On all other cycles strike = 0.
- frame_sync and code_valid in the same cycle: the byte's effect is included in that frame's snapshot; it is not deferred to the next frame.
- live_keys is registered and updates 1 cycle after code_valid.
- Multiple lanes may be held simultaneously; there is no rollover limit.

Decomposition:
- Shared game package holds:
  - the lane-count constant (8)
  - the PS/2 constants BREAK_PFX = 8'hF0 and EXT_PFX = 8'hE0
  - an enum typedef for the decoder states
- Natural sub-module: scancode_lane_map. It is combinational, maps code_byte to a one-hot 8-bit lane vector plus a hit flag, and is reusable by a future menu-key decoder.
- FSM, timeout, pending register and frame latch all live in key_tracker.

Test Plan:
1. Reset asserted mid-stream after bytes 1C, F0 -> all outputs 0 immediately (async); after release, bytes 23 then frame_sync -> keyTrack = 8'h20, strike = 8'h20 for exactly 1 cycle.
2. Bytes 1C, 4C, then frame_sync -> keyTrack = 8'h81, strike = 8'h81. Then F0 1C plus frame_sync -> keyTrack = 8'h01, strike = 0.
3. Bytes 3B, F0, 3B all within one frame, then frame_sync -> keyTrack = 8'h00, strike = 8'h08.
4. Typematic: 42 repeated 5 times across 2 frames -> strike = 8'h04 only at the first frame_sync; keyTrack = 8'h04 in both frames.
5. Extended: E0 F0 1C, then plain 1C -> lane 7 set only by the final byte. Also, E0 with no following byte for PREFIX_TIMEOUT cycles -> err_timeout pulses once, FSM back in IDLE, and a subsequent 1B sets lane 6.
6. code_valid=1 with byte 2B in the same cycle as frame_sync -> keyTrack = 8'h10 and strike = 8'h10 on the next cycle; live_keys = 8'h10.
